intr_sequencer: RTL and testbench

- Interrupt sequencer for the pipelined MIPS core; sits between the I/O devices and the pipelined control unit.
- Latches device requests, arbitrates them by fixed priority, and owns the IE flag register.
- Drives the single intr/IE pair into the control unit and sequences ISR entry: one intr cycle, a pipeline flush window, then the device acknowledge.
- Decodes nothing itself; consumes setie/reti strobes from the ID stage and restores IE on return.

---
 rtl/intr_sequencer_pkg.sv | 16 +
 rtl/intr_sequencer_prio_enc.sv | 22 ++
 rtl/intr_sequencer.sv | 147 ++++++++++++++
 tb/tb_intr_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/intr_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer and the pipelined control unit:
// FSM state encoding and the ISR vector location both sides agree on.
package intr_sequencer_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ENTRY  = 3'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACK    = 3'd3;
    localparam logic [STATE_W-1:0] ST_IN_ISR = 3'd4;

    // Fetch address the control unit redirects to when intr is taken.
    localparam logic [31:0] ISR_VECTOR_ADDR = 32'h0000_03FC;

endpackage

// File: rtl/intr_sequencer_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and
// the index of the lowest set bit.
module prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx   = req[i] ? W'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt sequencer: latches device requests, owns IE, and walks the core
// through ISR entry (intr, pipeline flush, device acknowledge) and return.
module intr_sequencer
    import intr_sequencer_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int FLUSH_CYCLES = 3,
    parameter int ID_W         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic               stall,
    input  logic               setie,
    input  logic               reti,
    output logic               intr,
    output logic               IE,
    output logic               flush,
    output logic [NUM_SRC-1:0] intr_ack,
    output logic [ID_W-1:0]    isr_id,
    output logic               in_isr
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]   FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [NUM_SRC-1:0] ONE_HOT0   = {{(NUM_SRC-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0] state_r, state_next_s;
    logic [NUM_SRC-1:0] pending_r, pending_next_s;
    logic               ie_r, ie_next_s;
    logic [CNT_W-1:0]   flush_cnt_r, flush_cnt_next_s;
    logic [ID_W-1:0]    isr_id_r, isr_id_next_s;
    logic [NUM_SRC-1:0] ack_vec_s;

    logic               intr_r;
    logic               flush_r;
    logic [NUM_SRC-1:0] intr_ack_r;
    logic               in_isr_r;

    logic               enc_valid_s;
    logic [ID_W-1:0]    enc_idx_s;

    prio_enc #(
        .N (NUM_SRC),
        .W (ID_W)
    ) u_prio_enc (
        .req   (pending_r),
        .valid (enc_valid_s),
        .idx   (enc_idx_s)
    );

    // Next-state, flush down-counter and serviced-source selection.
    always_comb begin
        state_next_s     = state_r;
        flush_cnt_next_s = flush_cnt_r;
        isr_id_next_s    = isr_id_r;
        case (state_r)
            ST_IDLE: begin
                if (ie_r && enc_valid_s && !stall) begin
                    state_next_s  = ST_ENTRY;
                    isr_id_next_s = enc_idx_s;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                state_next_s     = ST_FLUSH;
                flush_cnt_next_s = FLUSH_LOAD;
            end
            ST_FLUSH: begin
                if (flush_cnt_r <= CNT_W'(1)) begin
                    state_next_s     = ST_ACK;
                    flush_cnt_next_s = {CNT_W{1'b0}};
                end else begin
                    flush_cnt_next_s = flush_cnt_r - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_next_s = ST_IN_ISR;
            end
            ST_IN_ISR: begin
                if (reti) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_IN_ISR;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                flush_cnt_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // IE priority: entry clears, then return restores, then setie, else hold.
    always_comb begin
        ie_next_s = ie_r;
        if (state_r == ST_ENTRY) begin
            ie_next_s = 1'b0;
        end else if (reti && (state_r == ST_IN_ISR)) begin
            ie_next_s = 1'b1;
        end else if (setie) begin
            ie_next_s = 1'b1;
        end else begin
            ie_next_s = ie_r;
        end
    end

    // Sticky pending: the ack clears its bit, a concurrent request re-sets it.
    always_comb begin
        pending_next_s = (pending_r & ~intr_ack_r) | irq_req;
        ack_vec_s      = ONE_HOT0 << isr_id_next_s;
    end

    // State and registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pending_r   <= {NUM_SRC{1'b0}};
            ie_r        <= 1'b0;
            flush_cnt_r <= {CNT_W{1'b0}};
            isr_id_r    <= {ID_W{1'b0}};
            intr_r      <= 1'b0;
            flush_r     <= 1'b0;
            intr_ack_r  <= {NUM_SRC{1'b0}};
            in_isr_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pending_r   <= pending_next_s;
            ie_r        <= ie_next_s;
            flush_cnt_r <= flush_cnt_next_s;
            isr_id_r    <= isr_id_next_s;
            intr_r      <= (state_next_s == ST_ENTRY);
            flush_r     <= (state_next_s == ST_FLUSH);
            intr_ack_r  <= (state_next_s == ST_ACK) ? ack_vec_s : {NUM_SRC{1'b0}};
            in_isr_r    <= (state_next_s == ST_ACK) || (state_next_s == ST_IN_ISR);
        end
    end

    assign intr     = intr_r;
    assign IE       = ie_r;
    assign flush    = flush_r;
    assign intr_ack = intr_ack_r;
    assign isr_id   = isr_id_r;
    assign in_isr   = in_isr_r;

endmodule

// File: tb/tb_intr_sequencer.sv
// Directed self-checking bench for intr_sequencer with hand-computed
// expectations for entry latency, flush length, priority and IE handling.
module tb_intr_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_req;
    logic       stall;
    logic       setie;
    logic       reti;
    logic       intr;
    logic       IE;
    logic       flush;
    logic [3:0] intr_ack;
    logic [1:0] isr_id;
    logic       in_isr;

    int total = 0;
    int bad   = 0;

    intr_sequencer #(
        .NUM_SRC      (4),
        .FLUSH_CYCLES (3),
        .ID_W         (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_req  (irq_req),
        .stall    (stall),
        .setie    (setie),
        .reti     (reti),
        .intr     (intr),
        .IE       (IE),
        .flush    (flush),
        .intr_ack (intr_ack),
        .isr_id   (isr_id),
        .in_isr   (in_isr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the ENTRY cycle; walks flush and ack, ends in the IN_ISR cycle.
    task automatic service(input logic [1:0] id, input logic [3:0] oh);
        chk("entry_intr", intr, 1);
        chk("entry_ie", IE, 1);
        chk("entry_id", isr_id, id);
        chk("entry_flush", flush, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_on", flush, 1);
            chk("flush_intr", intr, 0);
            chk("flush_ie", IE, 0);
            chk("flush_ack", intr_ack, 0);
        end
        tick();
        chk("ack_vec", intr_ack, oh);
        chk("ack_in_isr", in_isr, 1);
        chk("ack_flush", flush, 0);
        tick();
        chk("isr_ack_clr", intr_ack, 0);
        chk("isr_in_isr", in_isr, 1);
        chk("isr_ie", IE, 0);
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("reti_in_isr", in_isr, 0);
        chk("reti_ie", IE, 1);
    endtask

    initial begin
        reset = 1'b1; irq_req = 4'b0000; stall = 1'b0; setie = 1'b0; reti = 1'b0;
        tick();
        tick();
        chk("rst_intr", intr, 0);
        chk("rst_ie", IE, 0);
        chk("rst_flush", flush, 0);
        chk("rst_ack", intr_ack, 0);
        chk("rst_id", isr_id, 0);
        chk("rst_in_isr", in_isr, 0);
        reset = 1'b0;

        // Single source 2
        setie = 1'b1; tick(); setie = 1'b0;
        chk("t1_ie_set", IE, 1);
        irq_req = 4'b0100; tick();
        chk("t1_pend_intr", intr, 0);
        tick(); irq_req = 4'b0000;
        service(2'd2, 4'b0100);
        do_reti();
        tick();
        chk("t1_no_reentry", intr, 0);

        // Simultaneous sources 1 and 3
        irq_req = 4'b1010; tick(); irq_req = 4'b0000;
        tick();
        service(2'd1, 4'b0010);
        do_reti();
        tick();
        service(2'd3, 4'b1000);
        do_reti();
        tick(); chk("t2_no_third_a", intr, 0);
        tick(); chk("t2_no_third_b", intr, 0);

        // IE=0: pulsed request stays pending; reti outside ISR is ignored
        reset = 1'b1; tick(); reset = 1'b0;
        irq_req = 4'b0001; tick(); irq_req = 4'b0000;
        tick(); chk("t3_ie0_a", intr, 0);
        reti = 1'b1; tick(); reti = 1'b0;
        chk("t3_reti_ignored_ie", IE, 0);
        chk("t3_ie0_b", intr, 0);
        setie = 1'b1; tick(); setie = 1'b0;
        chk("t3_setie_ie", IE, 1);
        chk("t3_setie_intr", intr, 0);
        tick();
        service(2'd0, 4'b0001);
        do_reti();

        // Stall blocks entry
        stall = 1'b1;
        irq_req = 4'b0010; tick(); irq_req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_stalled", intr, 0);
        end
        stall = 1'b0; tick();
        service(2'd1, 4'b0010);
        do_reti();

        // No nesting inside an ISR even with IE set
        irq_req = 4'b0100; tick(); irq_req = 4'b0000;
        tick();
        service(2'd2, 4'b0100);
        setie = 1'b1; tick(); setie = 1'b0;
        chk("t5_ie_in_isr", IE, 1);
        irq_req = 4'b0001; tick(); irq_req = 4'b0000;
        tick(); chk("t5_no_nest_a", intr, 0);
        tick(); chk("t5_no_nest_b", intr, 0);
        chk("t5_still_isr", in_isr, 1);
        do_reti();
        chk("t5_reti_intr", intr, 0);
        tick();
        service(2'd0, 4'b0001);
        do_reti();

        // Reset during FLUSH
        irq_req = 4'b1000; tick(); irq_req = 4'b0000;
        tick();
        chk("t6_entry", intr, 1);
        tick();
        chk("t6_in_flush", flush, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_flush", flush, 0);
        chk("t6_ie", IE, 0);
        chk("t6_ack", intr_ack, 0);
        chk("t6_intr", intr, 0);
        chk("t6_in_isr", in_isr, 0);
        chk("t6_id", isr_id, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_no_ack", intr_ack, 0);
        end
        setie = 1'b1; tick(); setie = 1'b0;
        tick(); chk("t6_pending_gone_a", intr, 0);
        tick(); chk("t6_pending_gone_b", intr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
